// File: rtl/fetch_if.sv
// Handshake/bus bundle between the fetch sequencer and the hazard/branch
// logic plus the IF datapath.
interface fetch_if #(
  parameter int unsigned IMEM_AW = 10
);
  logic               freeze;
  logic               BrTaken;
  logic [31:0]        br_addr;
  logic [31:0]        pc_out;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rd_en;
  logic               if_reg_en;
  logic               if_reg_flush;
  logic               fetch_valid;
  logic               misalign_err;
  logic [31:0]        fetch_cnt;

  // Sequencer side
  modport master (
    input  freeze, BrTaken, br_addr,
    output pc_out, imem_addr, imem_rd_en, if_reg_en, if_reg_flush,
           fetch_valid, misalign_err, fetch_cnt
  );

  // Hazard/branch logic and IF datapath side
  modport slave (
    output freeze, BrTaken, br_addr,
    input  pc_out, imem_addr, imem_rd_en, if_reg_en, if_reg_flush,
           fetch_valid, misalign_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem reads and the IF/ID
// register load/flush, and arbitrates stalls against branch redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned IMEM_AW      = 10,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {StBoot, StRun, StStall, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] boot_cnt_q, boot_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;

  // State and datapath registers; reset aborts any state immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      boot_cnt_q  <= BOOT_CYCLES - 1;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_cnt_q  <= boot_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  // Next-state logic; a redirect outranks a stall request outside BOOT
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    boot_cnt_d  = boot_cnt_q;
    flush_cnt_d = flush_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = misalign_q;

    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == 32'd0) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q - 32'd1;
        end
      end
      StRun: begin
        if (!bus.BrTaken && bus.freeze) begin
          state_d = StStall;
        end else if (!bus.BrTaken) begin
          pc_d        = pc_q + PC_STEP;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      StStall: begin
        // Leaving STALL re-presents the held PC rather than advancing it
        if (!bus.BrTaken && !bus.freeze) begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (!bus.BrTaken) begin
          if (flush_cnt_q == 32'd0) begin
            state_d = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q - 32'd1;
          end
        end
      end
      default: state_d = StBoot;
    endcase

    // Redirect handling shared by RUN, STALL and FLUSH
    if (bus.BrTaken && (state_q != StBoot)) begin
      state_d     = StFlush;
      pc_d        = {bus.br_addr[31:2], 2'b00};
      flush_cnt_d = FLUSH_CYCLES - 1;
      if (bus.br_addr[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  // Moore control outputs decoded from the current state
  always_comb begin
    bus.imem_rd_en   = 1'b0;
    bus.if_reg_en    = 1'b0;
    bus.if_reg_flush = 1'b1;
    bus.fetch_valid  = 1'b0;
    unique case (state_q)
      StBoot: begin
        bus.if_reg_flush = 1'b1;
      end
      StRun: begin
        bus.imem_rd_en   = 1'b1;
        bus.if_reg_en    = 1'b1;
        bus.if_reg_flush = 1'b0;
        bus.fetch_valid  = 1'b1;
      end
      StStall: begin
        bus.imem_rd_en   = 1'b1;
        bus.if_reg_flush = 1'b0;
      end
      StFlush: begin
        bus.imem_rd_en   = 1'b1;
        bus.if_reg_flush = 1'b1;
      end
      default: begin
        bus.if_reg_flush = 1'b1;
      end
    endcase
  end

  assign bus.pc_out       = pc_q;
  assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with default parameters.
module tb_fetch_ctrl;

  // {imem_rd_en, if_reg_en, if_reg_flush, fetch_valid}
  localparam logic [3:0] C_BOOT  = 4'b0010;
  localparam logic [3:0] C_RUN   = 4'b1101;
  localparam logic [3:0] C_STALL = 4'b1000;
  localparam logic [3:0] C_FLUSH = 4'b1010;

  typedef struct {
    logic        freeze;
    logic        br;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  fetch_if #(.IMEM_AW(10)) bus ();

  fetch_ctrl #(
    .RESET_PC    (32'd0),
    .PC_STEP     (4),
    .IMEM_AW     (10),
    .BOOT_CYCLES (2),
    .FLUSH_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [3:0] ctrl,
                         input logic [31:0] cnt, input logic mis);
    logic [9:0] exp_ia;
    exp_ia = pc[11:2];
    chk(tag, "pc_out", bus.pc_out, pc);
    chk(tag, "imem_addr", {22'd0, bus.imem_addr}, {22'd0, exp_ia});
    chk(tag, "ctrl", {28'd0, bus.imem_rd_en, bus.if_reg_en, bus.if_reg_flush,
                      bus.fetch_valid}, {28'd0, ctrl});
    chk(tag, "fetch_cnt", bus.fetch_cnt, cnt);
    chk(tag, "misalign_err", {31'd0, bus.misalign_err}, {31'd0, mis});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic b, input logic [31:0] a);
    bus.freeze  = f;
    bus.BrTaken = b;
    bus.br_addr = a;
  endtask

  initial begin
    // Each row: inputs applied before an edge, outputs expected after it
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        C_BOOT,  32'd0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        C_RUN,   32'd0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        C_RUN,   32'd1,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h8,        C_RUN,   32'd2,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        C_STALL, 32'd2,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        C_STALL, 32'd2,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        C_STALL, 32'd2,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h8,        C_RUN,   32'd2,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hC,        C_RUN,   32'd3,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h40,       32'h40,       C_FLUSH, 32'd3,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h40,       C_RUN,   32'd3,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h44,       C_RUN,   32'd4,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h80,       32'h80,       C_FLUSH, 32'd4,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h80,       C_RUN,   32'd4,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h80,       C_STALL, 32'd4,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h103,      32'h100,      C_FLUSH, 32'd4,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h100,      C_RUN,   32'd4,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h104,      C_RUN,   32'd5,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h200,      32'h200,      C_FLUSH, 32'd5,  1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h200,      C_RUN,   32'd5,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h204,      C_RUN,   32'd6,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h300,      32'h300,      C_FLUSH, 32'd6,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h400,      32'h400,      C_FLUSH, 32'd6,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h400,      C_RUN,   32'd6,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h404,      C_RUN,   32'd7,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'hFF8,      32'hFF8,      C_FLUSH, 32'd7,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hFF8,      C_RUN,   32'd7,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hFFC,      C_RUN,   32'd8,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h1000,     C_RUN,   32'd9,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, C_FLUSH, 32'd9,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, C_RUN,   32'd9,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        C_RUN,   32'd10, 1'b1});

    // Reset values are visible before any clock edge
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    #2;
    chk_all("reset", 32'h0, C_BOOT, 32'd0, 1'b0);
    step();
    rst = 1'b0;
    chk_all("boot0", 32'h0, C_BOOT, 32'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].freeze, vecs[i].br, vecs[i].addr);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].ctrl, vecs[i].cnt, vecs[i].mis);
    end

    // Asynchronous reset in the middle of FLUSH
    drive(1'b0, 1'b1, 32'h500);
    step();
    chk_all("preflush", 32'h500, C_FLUSH, 32'd10, 1'b1);
    drive(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, C_BOOT, 32'd0, 1'b0);
    step();
    rst = 1'b0;

    // BOOT ignores redirect and stall requests
    drive(1'b1, 1'b1, 32'h700);
    step();
    chk_all("reboot0", 32'h0, C_BOOT, 32'd0, 1'b0);
    step();
    chk_all("reboot1", 32'h0, C_RUN, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk_all("reboot2", 32'h4, C_RUN, 32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
